// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-through data cache with
// multi-word lines, burst refill and per-set round-robin replacement.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   cpu_addr             : byte address (bits [1:0] ignored)
//   cpu_write_data       : store data
//   cpu_read, cpu_write  : load / store request (store wins)
//   cpu_read_data        : load data from the hitting way (combinational)
//   cpu_stall            : CPU must hold its request while high
//   hit                  : request present and a valid way matches
//   mem_read_data        : memory read data, valid when !mem_busy
//   mem_busy             : memory not ready this cycle
//   mem_addr             : word-aligned memory address
//   mem_write_data       : memory write data
//   mem_read, mem_write  : memory read / write request
//   hit_count,miss_count : access counters (CACHE_STATS_EN only)
//
// Optional feature macro: CACHE_STATS_EN adds the hit/miss counters.

module set_assoc_cache #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int SETS        = 64,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_stall,
  output logic                  hit,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OW  = $clog2(BLOCK_WORDS);
  localparam int FCW = (OW > 0) ? OW : 1;
  localparam int IW  = $clog2(SETS);
  localparam int RW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAW = ADDR_WIDTH - 2;
  localparam int TW  = WAW - OW - IW;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_t;

  // Address split on the word address
  logic [WAW-1:0] waddr;
  logic [FCW-1:0] off;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  tag;
  logic           unused_addr;

  assign waddr       = cpu_addr[ADDR_WIDTH-1:2];
  assign off         = (OW > 0) ? FCW'(waddr) : '0;
  assign idx         = IW'(waddr >> OW);
  assign tag         = TW'(waddr >> (OW + IW));
  assign unused_addr = ^cpu_addr[1:0];

  // Storage
  logic                  valid_q [SETS][WAYS];
  logic [TW-1:0]         tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][BLOCK_WORDS];
  logic [RW-1:0]         rr_q    [SETS];

  state_t         state_q, state_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic [RW-1:0]  victim_q, victim_d;

  // Lookup
  logic [WAYS-1:0] match;
  logic [RW-1:0]   hway;
  logic            req;

  always_comb begin
    match = '0;
    hway  = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (match[w]) hway = RW'(w);
    end
  end

  assign req           = cpu_read | cpu_write;
  assign hit           = req && (|match);
  assign cpu_read_data = data_q[idx][hway][off];

  // Refill walks the line one word at a time from its base
  logic [WAW-1:0] fill_waddr;
  logic           fc_last;
  logic [RW-1:0]  rr_nxt;

  assign fill_waddr = ((waddr >> OW) << OW) | WAW'(fc_q);
  assign fc_last    = (fc_q == FCW'(BLOCK_WORDS - 1));
  assign rr_nxt     = (WAYS == 1) ? '0 : rr_q[idx] + RW'(1);

  logic start_refill;
  logic fill_we;
  logic fill_last;
  logic wr_we;

  // Next state and outputs
  always_comb begin
    state_d        = state_q;
    fc_d           = fc_q;
    victim_d       = victim_q;
    cpu_stall      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = {waddr, 2'b00};
    mem_write_data = cpu_write_data;
    start_refill   = 1'b0;
    fill_we        = 1'b0;
    fill_last      = 1'b0;
    wr_we          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (cpu_write) begin
              mem_write = 1'b1;
              wr_we     = 1'b1;
              if (mem_busy) begin
                cpu_stall = 1'b1;
                state_d   = WRITE;
              end
            end
          end else begin
            cpu_stall    = 1'b1;
            start_refill = 1'b1;
            victim_d     = rr_q[idx];
            fc_d         = '0;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_read  = 1'b1;
        mem_addr  = {fill_waddr, 2'b00};
        if (!mem_busy) begin
          fill_we = 1'b1;
          fc_d    = fc_q + FCW'(1);
          if (fc_last) begin
            fill_last = 1'b1;
            fc_d      = '0;
            state_d   = IDLE;
          end
        end
      end
      WRITE: begin
        // Word already updated; CPU is released once memory accepts
        mem_write = 1'b1;
        cpu_stall = mem_busy;
        if (!mem_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits and replacement pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      fc_q     <= '0;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      victim_q <= victim_d;
      // Invalidate the victim up front so a partial line never hits
      if (start_refill) valid_q[idx][rr_q[idx]] <= 1'b0;
      if (fill_last) begin
        for (int w = 0; w < WAYS; w++) begin
          if (RW'(w) != victim_q && tag_q[idx][w] == tag)
            valid_q[idx][w] <= 1'b0;
        end
        valid_q[idx][victim_q] <= 1'b1;
        rr_q[idx]              <= rr_nxt;
      end
    end
  end

  // Tag and data arrays need no reset: valid bits gate them
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_we) data_q[idx][victim_q][fc_q] <= mem_read_data;
      if (fill_last) tag_q[idx][victim_q] <= tag;
      if (wr_we) data_q[idx][hway][off] <= cpu_write_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        first_q;

  // first_q marks the access that completes a refill, already a miss
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      first_q    <= 1'b0;
    end else begin
      if (start_refill) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (fill_last) begin
        first_q <= 1'b1;
      end else if (hit && !cpu_stall) begin
        if (!first_q) hit_cnt_q <= hit_cnt_q + 32'd1;
        first_q <= 1'b0;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative data cache with multi-word blocks, write-through/write-allocate policy and a per-set round-robin replacement pointer. It sits between the pipeline MEM stage and main memory, in the same slot and with the same CPU/memory handshake as the single-word direct-mapped data cache. It generalises that cache in associativity, line size and address width. It refills a whole block with a burst of single-word memory reads.

## Interface
- `DATA_WIDTH`, 32, word width in bits
- `ADDR_WIDTH`, 32, byte address width
- `SETS`, 64, number of sets; power of 2, ≥2
- `WAYS`, 2, ways per set; power of 2: 1, 2 or 4
- `BLOCK_WORDS`, 4, words per line; power of 2, ≥1
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `cpu_addr` in ADDR_WIDTH: byte address; bits [1:0] ignored
- `cpu_write_data` in DATA_WIDTH: store data
- `cpu_read` in 1: load request
- `cpu_write` in 1: store request; has priority if both are high
- `cpu_read_data` out DATA_WIDTH: load data, combinational from the hit way
- `cpu_stall` out 1: the CPU must hold its request while this is high
- `hit` out 1: tag match in a valid way with a request present
- `mem_read_data` in DATA_WIDTH: memory read data, valid when `!mem_busy`
- `mem_busy` in 1: memory not ready this cycle
- `mem_addr` out ADDR_WIDTH: word-aligned memory address
- `mem_write_data` out DATA_WIDTH: memory write data
- `mem_read` out 1: memory read request
- `mem_write` out 1: memory write request
- `hit_count` out 32: accepted hits (only with `CACHE_STATS_EN`)
- `miss_count` out 32: misses (only with `CACHE_STATS_EN`)

## Operation
- **Address split**
  - offset = `cpu_addr[OW+1:2]`, where OW = log2(BLOCK_WORDS)
  - index = next log2(SETS) bits
  - tag = the remaining upper bits
- **Storage per way/set:** valid bit, tag, and BLOCK_WORDS data words. Each set also has a log2(WAYS)-bit round-robin pointer, `rr`.
- **Hit:** `hit = (cpu_read|cpu_write) && OR over ways of (valid && tag match)`. At most one way can match.
- **FSM states:** IDLE, REFILL, WRITE.
- **IDLE**
  - Read hit: `cpu_read_data` = matched word, `cpu_stall=0`.
  - Write hit: asserts `mem_write=1` with `mem_addr={cpu_addr[ADDR_WIDTH-1:2],2'b00}` and updates the cached word at the clock edge.
    - If `mem_busy=0` this cycle, `cpu_stall=0` and the write is done.
    - Otherwise `cpu_stall=1` and the FSM goes to WRITE.
  - Miss (read or write): `cpu_stall=1`, victim way = `rr[index]`, fill counter `fc`=0, go to REFILL.
- **REFILL**
  - `mem_read=1` with `mem_addr` = block base + fc·4.
  - On each cycle with `!mem_busy`, write `mem_read_data` into victim word `fc` and increment `fc`.
  - On the final word:
    - set valid and tag for the victim way;
    - clear valid on any other way of the set with the same tag (never expected, but required);
    - `rr[index]` ← `rr[index]+1`, wrapping modulo WAYS;
    - return to IDLE.
  - The victim's valid bit is cleared on entry to REFILL, so a partially filled line is never hit.
  - Back in IDLE the request is re-evaluated as a hit: a read is released, a write takes the write-hit path.
- **WRITE:** hold `mem_write=1`, `cpu_stall=1`; return to IDLE when `!mem_busy`. The cached word is already updated.
- **No writeback:** write-through means no dirty state, and eviction writes nothing back.
- **Request changes while stalled:** undefined; the CPU must hold the request.

## Timing
- **Reset values:** `state`=IDLE, all valid=0, all `rr`=0, `fc`=0, `mem_read`=`mem_write`=0, counters=0. Outputs reach these values the cycle after `reset` is sampled high.
- **Reset mid-REFILL or mid-WRITE:** aborts the operation. The line stays invalid, and `mem_read`/`mem_write` are 0 from the next cycle.
- **Read hit:** 0 stall cycles.
- **Read miss:** stall = BLOCK_WORDS × (memory wait + 1) + 1 cycles. With zero-wait memory and BLOCK_WORDS=4, `cpu_stall` is high for 5 cycles.
- **Write hit with zero-wait memory:** 0 stall cycles.
- **Write miss:** refill stall, then the write-hit timing.
- **Data arrays:** written only at clock edges. `cpu_read_data` is don't-care when `hit=0`.

## Configuration
- **`CACHE_STATS_EN` defined:** the `hit_count`/`miss_count` ports and 32-bit wrapping counters exist.
  - `miss_count` +1 on each IDLE→REFILL transition.
  - `hit_count` +1 on each cycle where `hit && !cpu_stall`, except the first access completed after a refill (flagged internally), so a miss counts once.
- **Not defined:** no ports, counters or flag; functional behaviour is identical.

## Test plan
- Reset, then read 0x0000_0100 with zero-wait memory returning 0xA0+word → `mem_read` at 0x100, 0x104, 0x108, 0x10C; stall 5 cycles; `cpu_read_data`=0xA0. A following read of 0x108 hits with no stall and returns 0xA2.
- Read 0x100, then 0x1100 and 0x2100 (same set, WAYS=2) → the third access evicts way 0 (0x100 line); re-reading 0x1100 hits and re-reading 0x100 misses.
- Write hit 0x104 ← 0xDEADBEEF with `mem_busy` high for 2 cycles → `mem_write` held 3 cycles, stall 2 cycles; a subsequent read returns 0xDEADBEEF.
- Write miss 0x300 ← 0x55 → 4-word refill, then one `mem_write` at 0x300 with 0x55; read 0x300 = 0x55.
- Assert `reset` during the 2nd refill word → `mem_read`=0 next cycle; a re-read of the same address misses and refills all 4 words.
- With `CACHE_STATS_EN`: sequence miss, hit, hit, write-hit → `miss_count`=1, `hit_count`=3.
